// File: rtl/sine_envelope_shaper.sv
// ADSR envelope applied to a signed 16-bit sine stream; envelope steps on a divided tick.
// Sample path has 1 clock of latency; no backpressure, one sample is accepted every clock.
module sine_envelope_shaper #(
  parameter int TICK_DIV = 16,
  parameter int TICK_W   = 16
) (
  input  logic        clk_1mhz,
  input  logic        reset,
  input  logic [15:0] sample_in,
  input  logic        gate,
  input  logic [15:0] attack_inc,
  input  logic [15:0] decay_dec,
  input  logic [15:0] sustain_lvl,
  input  logic [15:0] release_dec,
  output logic [15:0] sample_out,
  output logic [15:0] env_out,
  output logic [2:0]  state_out,
  output logic        busy
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ATTACK  = 3'd1,
    DECAY   = 3'd2,
    SUSTAIN = 3'd3,
    RELEASE = 3'd4
  } env_state_t;

  env_state_t        state, state_nxt;
  logic [15:0]       env, env_nxt;
  logic [TICK_W-1:0] tick_cnt;
  logic              tick;
  logic              gate_q;
  logic              rise;
  logic              busy_q;

  logic [16:0]        atk_sum;
  logic [16:0]        dcy_thr;
  logic signed [32:0] prod;
  logic               unused_prod_bits;

  assign tick = (tick_cnt == TICK_W'(TICK_DIV - 1));
  assign rise = gate & ~gate_q;

  always_ff @(posedge clk_1mhz) begin
    if (reset) begin
      tick_cnt <= '0;
      gate_q   <= 1'b0;
    end else begin
      gate_q   <= gate;
      tick_cnt <= tick ? '0 : tick_cnt + TICK_W'(1);
    end
  end

  assign atk_sum = {1'b0, env} + {1'b0, attack_inc};
  assign dcy_thr = {1'b0, sustain_lvl} + {1'b0, decay_dec};

  // Gate edges win over the tick, and the envelope holds in those cycles.
  always_comb begin
    state_nxt = state;
    env_nxt   = env;
    if (rise) begin
      state_nxt = ATTACK;
    end else if (!gate && (state == ATTACK || state == DECAY || state == SUSTAIN)) begin
      state_nxt = RELEASE;
    end else if (tick) begin
      case (state)
        ATTACK: begin
          if (atk_sum >= 17'h0FFFF) begin
            env_nxt   = 16'hFFFF;
            state_nxt = DECAY;
          end else begin
            env_nxt = atk_sum[15:0];
          end
        end
        DECAY: begin
          if ({1'b0, env} <= dcy_thr) begin
            env_nxt   = sustain_lvl;
            state_nxt = SUSTAIN;
          end else begin
            env_nxt = env - decay_dec;
          end
        end
        SUSTAIN: env_nxt = sustain_lvl;
        RELEASE: begin
          if (env <= release_dec) begin
            env_nxt   = 16'h0000;
            state_nxt = IDLE;
          end else begin
            env_nxt = env - release_dec;
          end
        end
        default: env_nxt = 16'h0000;
      endcase
    end
  end

  always_ff @(posedge clk_1mhz) begin
    if (reset) begin
      state  <= IDLE;
      env    <= 16'h0000;
      busy_q <= 1'b0;
    end else begin
      state  <= state_nxt;
      env    <= env_nxt;
      busy_q <= (state_nxt != IDLE);
    end
  end

  // env < 2^16, so product >>> 16 always fits in 16 signed bits.
  assign prod             = $signed(sample_in) * $signed({1'b0, env});
  assign unused_prod_bits = ^{prod[32], prod[15:0]};

  always_ff @(posedge clk_1mhz) begin
    if (reset) begin
      sample_out <= 16'h0000;
    end else begin
      sample_out <= prod[31:16];
    end
  end

  assign env_out   = env;
  assign state_out = state;
  assign busy      = busy_q;

endmodule
